fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//   Sequences the instruction memory. Owns the ProgramCounter and pulses FetchStrobe,
//   which drives the memory read clock/enable. Holds the core while an IN instruction
//   waits for the operator, and stops the core on HALT or on an out-of-range PC.
//   Sits between the instruction memory and the control unit/datapath.
// PARAMETERS
//   MEM_DEPTH  100        number of instruction words; legal PC range is 0..MEM_DEPTH-1
//   START_PC   0          PC loaded on reset and on Run
//   OP_HALT    6'b000001  opcode in Instruction[31:26] that stops the core
//   OP_IN      6'b001011  opcode in Instruction[31:26] that waits for InputConfirm
// PORTS
//   Clock          in   1   core clock; all state changes on posedge
//   Reset          in   1   asynchronous reset, active-high
//   Run            in   1   start/restart request; level, sampled in IDLE/HALTED only
//   Instruction    in   32  instruction memory read data, valid in the cycle after FetchStrobe
//   BranchTaken    in   1   datapath: take BranchTarget; sampled only while InstrValid=1
//   BranchTarget   in   32  next PC when BranchTaken=1
//   InputConfirm   in   1   operator input accepted (debounced, 1-cycle pulse)
//   ProgramCounter out  32  current fetch address into instruction memory
//   FetchStrobe    out  1   1-cycle read pulse to instruction memory
//   InstrValid     out  1   Instruction is stable; datapath executes/commits this cycle
//   WaitingInput   out  1   core is held on an IN instruction
//   Halted         out  1   core is stopped (HALT or fault)
//   Fault          out  1   stop was caused by an out-of-range PC
//   RetiredCount   out  32  number of committed instructions; saturates at 32'hFFFFFFFF
// BEHAVIOUR
//   Reset (async): state=IDLE, ProgramCounter=START_PC, RetiredCount=0.
//     All 1-bit outputs are 0 during and after reset, except Halted, which is 0 in IDLE.
//   FSM states: IDLE, FETCH, LATCH, WAIT_IN, EXEC, HALTED.
//   IDLE:    Run=1 -> FETCH, PC<=START_PC.
//   FETCH:   FetchStrobe=1 for exactly this cycle -> LATCH.
//   LATCH:   memory data settles; decodes Instruction[31:26].
//            OP_IN -> WAIT_IN; all other opcodes -> EXEC.
//   WAIT_IN: WaitingInput=1; stays until InputConfirm=1, then -> EXEC.
//            InputConfirm arriving in any other state is ignored (not queued).
//   EXEC:    InstrValid=1 for exactly one cycle.
//            OP_HALT: PC unchanged, RetiredCount+1 -> HALTED.
//            Otherwise: next = BranchTaken ? BranchTarget : PC+1 (32-bit, no wrap).
//              next >= MEM_DEPTH -> PC unchanged, Fault<=1 -> HALTED; the instruction
//                                   still counts as retired.
//              Else PC<=next, RetiredCount+1 -> FETCH.
//   HALTED:  Halted=1. PC, Fault and RetiredCount are held.
//            Run=1 -> PC<=START_PC, Fault<=0, RetiredCount<=0 -> FETCH.
//   Run while in FETCH/LATCH/WAIT_IN/EXEC is ignored.
//   Latency: FETCH to EXEC takes 3 cycles. A non-IN instruction takes 3 cycles end to end.
//   An IN instruction takes 3 cycles + the wait for InputConfirm.
//   RetiredCount saturates; it never wraps to 0 except through Run or Reset.
//   Reset asserted mid-operation (any state, including WAIT_IN) aborts immediately to
//   IDLE. No partial commit: InstrValid drops asynchronously.
//   ProgramCounter changes only on leaving EXEC or on a Run restart. It is therefore
//   stable from FETCH through EXEC.
// TESTING
//   1 Reset, then Run=1 with no branches and word 3 = HALT -> FetchStrobe at cycles
//     1,4,7,10; InstrValid 2 cycles after each strobe; PC 0->1->2->3; Halted=1,
//     RetiredCount=4, Fault=0.
//   2 Word 1 = j target 12, word 12 = HALT; BranchTaken=1, BranchTarget=12 in the EXEC
//     of word 1 -> PC goes 1->12; Halted with RetiredCount=3.
//   3 Word 5 = IN; InputConfirm pulsed 10 cycles after WaitingInput rises -> InstrValid
//     on the cycle after the pulse. An InputConfirm pulse during FETCH has no effect.
//   4 Branch to 150 with MEM_DEPTH=100 -> Fault=1, Halted=1, PC holds the branch's
//     address. Straight-line run past word 99 -> Fault at PC=99.
//   5 Assert Reset during WAIT_IN and during EXEC -> all outputs 0 and PC=START_PC in
//     the same cycle. A later Run restarts a clean fetch from START_PC.
//   6 From HALTED, pulse Run -> Fault and RetiredCount clear and fetch resumes at
//     START_PC. Run held high while running has no effect.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC and paces fetch, decode and commit.
// Strobes instruction memory, holds on IN, stops on HALT or bad PC.
module fetch_sequencer #(
  parameter int          MEM_DEPTH = 100,
  parameter logic [31:0] START_PC  = 32'd0,
  parameter logic [5:0]  OP_HALT   = 6'b000001,
  parameter logic [5:0]  OP_IN     = 6'b001011
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Run,
  input  logic [31:0] Instruction,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        InputConfirm,
  output logic [31:0] ProgramCounter,
  output logic        FetchStrobe,
  output logic        InstrValid,
  output logic        WaitingInput,
  output logic        Halted,
  output logic        Fault,
  output logic [31:0] RetiredCount
);

  localparam logic [31:0] DEPTH = 32'(MEM_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    WAIT_IN,
    EXEC,
    HALTED
  } state_t;

  state_t      state;
  state_t      stateNext;
  logic [5:0]  opcode;
  logic [5:0]  opcodeNext;
  logic [31:0] pcNext;
  logic [31:0] countNext;
  logic [31:0] target;
  logic        faultNext;

  // State register; reset drops every strobe output at once.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // PC, retire counter, fault flag and the opcode decoded in LATCH.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      ProgramCounter <= START_PC;
      RetiredCount   <= 32'd0;
      Fault          <= 1'b0;
      opcode         <= 6'd0;
    end else begin
      ProgramCounter <= pcNext;
      RetiredCount   <= countNext;
      Fault          <= faultNext;
      opcode         <= opcodeNext;
    end
  end

  // Next-state and outputs; PC only moves on leaving EXEC or on Run.
  always_comb begin
    stateNext    = state;
    pcNext       = ProgramCounter;
    countNext    = RetiredCount;
    faultNext    = Fault;
    opcodeNext   = opcode;
    FetchStrobe  = 1'b0;
    InstrValid   = 1'b0;
    WaitingInput = 1'b0;
    Halted       = 1'b0;
    target       = BranchTaken ? BranchTarget
                               : ProgramCounter + 32'd1;
    unique case (state)
      IDLE: begin
        if (Run) begin
          stateNext = FETCH;
          pcNext    = START_PC;
        end
      end
      FETCH: begin
        FetchStrobe = 1'b1;
        stateNext   = LATCH;
      end
      LATCH: begin
        opcodeNext = Instruction[31:26];
        if (Instruction[31:26] == OP_IN) begin
          stateNext = WAIT_IN;
        end else begin
          stateNext = EXEC;
        end
      end
      WAIT_IN: begin
        WaitingInput = 1'b1;
        if (InputConfirm) begin
          stateNext = EXEC;
        end
      end
      EXEC: begin
        InstrValid = 1'b1;
        if (RetiredCount != 32'hFFFF_FFFF) begin
          countNext = RetiredCount + 32'd1;
        end
        if (opcode == OP_HALT) begin
          stateNext = HALTED;
        end else if (target >= DEPTH) begin
          faultNext = 1'b1;
          stateNext = HALTED;
        end else begin
          pcNext    = target;
          stateNext = FETCH;
        end
      end
      HALTED: begin
        Halted = 1'b1;
        if (Run) begin
          pcNext    = START_PC;
          faultNext = 1'b0;
          countNext = 32'd0;
          stateNext = FETCH;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: random and directed programs against a
// per-instruction timing model of the fetch sequencer.
module tb_fetch_sequencer;

  localparam logic [31:0] START = 32'd0;
  localparam logic [5:0]  OP_HALT = 6'b000001;
  localparam logic [5:0]  OP_IN   = 6'b001011;

  logic        Clock;
  logic        Reset;
  logic        Run;
  logic [31:0] Instruction;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        InputConfirm;
  logic [31:0] ProgramCounter;
  logic        FetchStrobe;
  logic        InstrValid;
  logic        WaitingInput;
  logic        Halted;
  logic        Fault;
  logic [31:0] RetiredCount;

  int total = 0;
  int bad = 0;

  logic [31:0] mem [0:127];
  bit          brT [0:127];
  logic [31:0] brA [0:127];
  int          inWait [0:127];

  int          obsStrQ[$];
  int          obsValQ[$];
  logic [31:0] obsStrPcQ[$];
  logic [31:0] obsPcQ[$];
  logic [31:0] obsCntQ[$];
  bit          timedOut;

  int          expStrQ[$];
  int          expValQ[$];
  logic [31:0] expPcQ[$];
  logic [31:0] expCount;
  logic [31:0] expFinalPc;
  logic        expFault;

  fetch_sequencer dut (
    .Clock(Clock),
    .Reset(Reset),
    .Run(Run),
    .Instruction(Instruction),
    .BranchTaken(BranchTaken),
    .BranchTarget(BranchTarget),
    .InputConfirm(InputConfirm),
    .ProgramCounter(ProgramCounter),
    .FetchStrobe(FetchStrobe),
    .InstrValid(InstrValid),
    .WaitingInput(WaitingInput),
    .Halted(Halted),
    .Fault(Fault),
    .RetiredCount(RetiredCount)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // synchronous instruction memory read on the fetch strobe
  always @(posedge Clock)
    if (FetchStrobe) Instruction <= mem[ProgramCounter[6:0]];

  function automatic logic [5:0] rand_op();
    logic [5:0] o;
    do o = 6'($urandom); while (o == OP_HALT || o == OP_IN);
    return o;
  endfunction

  task automatic clear_prog();
    for (int p = 0; p < 128; p++) begin
      mem[p] = {rand_op(), 26'($urandom)};
      brT[p] = 1'b0;
      brA[p] = 32'd0;
      inWait[p] = 0;
    end
  endtask

  // Runs the program from a Run pulse until Halted or budget.
  // Cycle t=0 is the cycle Run is presented.
  task automatic execute(input int budget, input bit holdRun,
                         input bit spur);
    int t;
    int w;
    logic [6:0] a;
    obsStrQ.delete(); obsValQ.delete(); obsStrPcQ.delete();
    obsPcQ.delete(); obsCntQ.delete();
    timedOut = 1'b0;
    t = 0;
    w = 0;
    @(negedge Clock);
    Run = 1'b1;
    forever begin
      @(negedge Clock);
      t++;
      Run = holdRun;
      a = ProgramCounter[6:0];
      InputConfirm = spur && FetchStrobe;
      BranchTaken = 1'($urandom_range(0, 1));
      BranchTarget = $urandom;
      if (FetchStrobe) begin
        obsStrQ.push_back(t);
        obsStrPcQ.push_back(ProgramCounter);
      end
      if (InstrValid) begin
        obsValQ.push_back(t);
        obsPcQ.push_back(ProgramCounter);
        obsCntQ.push_back(RetiredCount);
        BranchTaken = brT[a];
        if (brT[a]) BranchTarget = brA[a];
      end
      if (WaitingInput) begin
        if (w == inWait[a]) InputConfirm = 1'b1;
        w++;
      end else begin
        w = 0;
      end
      if (Halted) break;
      if (t > budget) begin
        timedOut = 1'b1;
        break;
      end
    end
    Run = 1'b0;
    BranchTaken = 1'b0;
    InputConfirm = 1'b0;
  endtask

  // Instruction-level model: each instruction costs 3 cycles,
  // plus wait+1 for IN; HALT wins over any branch.
  task automatic model();
    logic [31:0] pc;
    logic [31:0] nxt;
    logic [5:0]  op;
    int tv;
    expStrQ.delete(); expValQ.delete(); expPcQ.delete();
    pc = START;
    tv = 0;
    expCount = 0;
    expFault = 1'b0;
    for (int k = 0; k < 300; k++) begin
      op = mem[pc[6:0]][31:26];
      expPcQ.push_back(pc);
      expStrQ.push_back(tv + 1);
      tv = tv + 3 + ((op == OP_IN) ? inWait[pc[6:0]] + 1 : 0);
      expValQ.push_back(tv);
      expCount++;
      if (op == OP_HALT) break;
      nxt = brT[pc[6:0]] ? brA[pc[6:0]] : pc + 1;
      if (nxt >= 32'd100) begin
        expFault = 1'b1;
        break;
      end
      pc = nxt;
    end
    expFinalPc = pc;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (2) @(negedge Clock);
    total++;
    if ({FetchStrobe, InstrValid, WaitingInput, Halted, Fault} !== 5'b0
        || ProgramCounter !== START || RetiredCount !== 32'd0) begin
      bad++;
      $display("FAIL reset_hold flags=%b pc=%0d cnt=%0d want 0/%0d/0",
        {FetchStrobe, InstrValid, WaitingInput, Halted, Fault},
        ProgramCounter, RetiredCount, START);
    end
    Reset = 1'b0;
    @(negedge Clock);
    total++;
    if (FetchStrobe !== 1'b0 || Halted !== 1'b0
        || ProgramCounter !== START) begin
      bad++;
      $display("FAIL reset_idle strobe=%b halted=%b pc=%0d want 0 0 %0d",
        FetchStrobe, Halted, ProgramCounter, START);
    end
  endtask

  task automatic test_straight();
    int eS[4] = '{1, 4, 7, 10};
    clear_prog();
    mem[3] = {OP_HALT, 26'h0};
    execute(200, 1'b0, 1'b0);
    total++;
    if (timedOut || obsValQ.size() != 4 || obsStrQ.size() != 4) begin
      bad++;
      $display("FAIL straight_len valid=%0d strobe=%0d want 4",
        obsValQ.size(), obsStrQ.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (obsStrQ[i] !== eS[i] || obsValQ[i] !== eS[i] + 2
            || obsPcQ[i] !== 32'(i) || obsStrPcQ[i] !== 32'(i)
            || obsCntQ[i] !== 32'(i)) begin
          bad++;
          $display("FAIL straight_%0d strobe=%0d valid=%0d pc=%0d want %0d %0d %0d",
            i, obsStrQ[i], obsValQ[i], obsPcQ[i], eS[i], eS[i] + 2, i);
        end
      end
    end
    total++;
    if (Halted !== 1'b1 || RetiredCount !== 32'd4 || Fault !== 1'b0
        || ProgramCounter !== 32'd3) begin
      bad++;
      $display("FAIL straight_end halted=%b cnt=%0d fault=%b pc=%0d want 1 4 0 3",
        Halted, RetiredCount, Fault, ProgramCounter);
    end
  endtask

  task automatic test_branch();
    int ePc[3] = '{0, 1, 12};
    clear_prog();
    brT[1] = 1'b1;
    brA[1] = 32'd12;
    mem[12] = {OP_HALT, 26'h0};
    execute(200, 1'b0, 1'b0);
    total++;
    if (timedOut || obsPcQ.size() != 3) begin
      bad++;
      $display("FAIL branch_len got=%0d want 3", obsPcQ.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (obsPcQ[i] !== 32'(ePc[i]) || obsValQ[i] !== 3 * i + 3) begin
          bad++;
          $display("FAIL branch_%0d pc=%0d t=%0d want %0d %0d",
            i, obsPcQ[i], obsValQ[i], ePc[i], 3 * i + 3);
        end
      end
    end
    total++;
    if (Halted !== 1'b1 || RetiredCount !== 32'd3
        || ProgramCounter !== 32'd12) begin
      bad++;
      $display("FAIL branch_end halted=%b cnt=%0d pc=%0d want 1 3 12",
        Halted, RetiredCount, ProgramCounter);
    end
  endtask

  task automatic test_in();
    clear_prog();
    mem[5] = {OP_IN, 26'h0};
    inWait[5] = 10;
    mem[6] = {OP_HALT, 26'h0};
    execute(300, 1'b0, 1'b1);
    total++;
    if (timedOut || obsValQ.size() != 7 || obsStrQ.size() != 7) begin
      bad++;
      $display("FAIL in_len valid=%0d strobe=%0d want 7",
        obsValQ.size(), obsStrQ.size());
    end else begin
      total++;
      if (obsStrQ[5] !== 16 || obsValQ[5] !== 29
          || obsStrQ[6] !== 30 || obsValQ[6] !== 32) begin
        bad++;
        $display("FAIL in_timing s5=%0d v5=%0d s6=%0d v6=%0d want 16 29 30 32",
          obsStrQ[5], obsValQ[5], obsStrQ[6], obsValQ[6]);
      end
    end
    total++;
    if (Halted !== 1'b1 || RetiredCount !== 32'd7
        || ProgramCounter !== 32'd6) begin
      bad++;
      $display("FAIL in_end halted=%b cnt=%0d pc=%0d want 1 7 6",
        Halted, RetiredCount, ProgramCounter);
    end
  endtask

  task automatic test_fault();
    clear_prog();
    brT[2] = 1'b1;
    brA[2] = 32'd150;
    execute(200, 1'b0, 1'b0);
    total++;
    if (timedOut || Fault !== 1'b1 || Halted !== 1'b1
        || ProgramCounter !== 32'd2 || RetiredCount !== 32'd3) begin
      bad++;
      $display("FAIL fault_branch fault=%b halted=%b pc=%0d cnt=%0d want 1 1 2 3",
        Fault, Halted, ProgramCounter, RetiredCount);
    end
    clear_prog();
    execute(1000, 1'b0, 1'b0);
    total++;
    if (timedOut || Fault !== 1'b1 || ProgramCounter !== 32'd99
        || RetiredCount !== 32'd100 || obsValQ.size() != 100) begin
      bad++;
      $display("FAIL fault_end fault=%b pc=%0d cnt=%0d n=%0d want 1 99 100 100",
        Fault, ProgramCounter, RetiredCount, obsValQ.size());
    end else begin
      total++;
      if (obsValQ[99] !== 300) begin
        bad++;
        $display("FAIL fault_last_t got=%0d want 300", obsValQ[99]);
      end
    end
  endtask

  task automatic test_restart();
    int k;
    mem[0] = {OP_HALT, 26'h0};
    @(negedge Clock);
    Run = 1'b1;
    @(negedge Clock);
    Run = 1'b0;
    total++;
    if (FetchStrobe !== 1'b1 || Fault !== 1'b0
        || RetiredCount !== 32'd0 || ProgramCounter !== START) begin
      bad++;
      $display("FAIL restart_clear strobe=%b fault=%b cnt=%0d pc=%0d want 1 0 0 %0d",
        FetchStrobe, Fault, RetiredCount, ProgramCounter, START);
    end
    for (k = 0; k < 10 && Halted !== 1'b1; k++) @(negedge Clock);
    total++;
    if (Halted !== 1'b1 || RetiredCount !== 32'd1 || Fault !== 1'b0) begin
      bad++;
      $display("FAIL restart_halt halted=%b cnt=%0d fault=%b want 1 1 0",
        Halted, RetiredCount, Fault);
    end
    clear_prog();
    mem[2] = {OP_HALT, 26'h0};
    execute(200, 1'b1, 1'b0);
    total++;
    if (timedOut || obsPcQ.size() != 3 || RetiredCount !== 32'd3
        || ProgramCounter !== 32'd2) begin
      bad++;
      $display("FAIL held_run n=%0d cnt=%0d pc=%0d want 3 3 2",
        obsPcQ.size(), RetiredCount, ProgramCounter);
    end
  endtask

  task automatic test_reset_mid();
    int k;
    clear_prog();
    mem[1] = {OP_IN, 26'h0};
    @(negedge Clock);
    Run = 1'b1;
    @(negedge Clock);
    Run = 1'b0;
    for (k = 0; k < 30 && WaitingInput !== 1'b1; k++) @(negedge Clock);
    #2 Reset = 1'b1;
    #1;
    total++;
    if ({FetchStrobe, InstrValid, WaitingInput, Halted, Fault} !== 5'b0
        || ProgramCounter !== START || RetiredCount !== 32'd0
        || k >= 30) begin
      bad++;
      $display("FAIL reset_wait flags=%b pc=%0d cnt=%0d k=%0d want 0/%0d/0",
        {FetchStrobe, InstrValid, WaitingInput, Halted, Fault},
        ProgramCounter, RetiredCount, START, k);
    end
    @(negedge Clock);
    Reset = 1'b0;
    mem[1] = {rand_op(), 26'h0};
    @(negedge Clock);
    Run = 1'b1;
    @(negedge Clock);
    Run = 1'b0;
    for (k = 0; k < 30; k++) begin
      if (InstrValid === 1'b1 && ProgramCounter === 32'd1) break;
      @(negedge Clock);
    end
    #2 Reset = 1'b1;
    #1;
    total++;
    if ({FetchStrobe, InstrValid, WaitingInput, Halted, Fault} !== 5'b0
        || ProgramCounter !== START || RetiredCount !== 32'd0
        || k >= 30) begin
      bad++;
      $display("FAIL reset_exec flags=%b pc=%0d cnt=%0d k=%0d want 0/%0d/0",
        {FetchStrobe, InstrValid, WaitingInput, Halted, Fault},
        ProgramCounter, RetiredCount, START, k);
    end
    @(negedge Clock);
    Reset = 1'b0;
    mem[2] = {OP_HALT, 26'h0};
    execute(200, 1'b0, 1'b0);
    total++;
    if (timedOut || obsPcQ.size() != 3 || obsValQ.size() != 3) begin
      bad++;
      $display("FAIL reset_rerun_len got=%0d want 3", obsPcQ.size());
    end else begin
      total++;
      if (obsPcQ[0] !== 32'd0 || obsPcQ[2] !== 32'd2
          || obsValQ[0] !== 3 || RetiredCount !== 32'd3) begin
        bad++;
        $display("FAIL reset_rerun pc0=%0d pc2=%0d t0=%0d cnt=%0d want 0 2 3 3",
          obsPcQ[0], obsPcQ[2], obsValQ[0], RetiredCount);
      end
    end
  endtask

  task automatic test_random();
    int r;
    int n;
    bit hold;
    bit spur;
    for (int it = 0; it < 12; it++) begin
      for (int p = 0; p < 128; p++) begin
        r = $urandom_range(0, 99);
        mem[p] = {r < 6 ? OP_HALT : (r < 16 ? OP_IN : rand_op()),
                  26'($urandom)};
        brT[p] = ($urandom_range(0, 7) == 0);
        r = $urandom_range(0, 9);
        brA[p] = (r == 0) ? $urandom
               : (r < 3) ? 32'(100 + $urandom_range(0, 50))
               : 32'(p + 1 + $urandom_range(0, 6));
        inWait[p] = $urandom_range(0, 4);
      end
      hold = 1'($urandom_range(0, 1));
      spur = 1'($urandom_range(0, 1));
      model();
      execute(3000, hold, spur);
      total++;
      if (timedOut || obsValQ.size() != expValQ.size()
          || obsStrQ.size() != expStrQ.size()) begin
        bad++;
        $display("FAIL rnd%0d_len valid=%0d strobe=%0d want %0d",
          it, obsValQ.size(), obsStrQ.size(), expValQ.size());
      end
      n = obsValQ.size();
      if (obsStrQ.size() < n) n = obsStrQ.size();
      if (expValQ.size() < n) n = expValQ.size();
      for (int i = 0; i < n; i++) begin
        total++;
        if (obsValQ[i] !== expValQ[i] || obsStrQ[i] !== expStrQ[i]
            || obsPcQ[i] !== expPcQ[i] || obsStrPcQ[i] !== expPcQ[i]
            || obsCntQ[i] !== 32'(i)) begin
          bad++;
          $display("FAIL rnd%0d_i%0d t=%0d/%0d pc=%0d/%0d cnt=%0d want t=%0d/%0d pc=%0d cnt=%0d",
            it, i, obsStrQ[i], obsValQ[i], obsStrPcQ[i], obsPcQ[i],
            obsCntQ[i], expStrQ[i], expValQ[i], expPcQ[i], i);
        end
      end
      total++;
      if (Halted !== 1'b1 || Fault !== expFault
          || RetiredCount !== expCount
          || ProgramCounter !== expFinalPc) begin
        bad++;
        $display("FAIL rnd%0d_end halted=%b fault=%b cnt=%0d pc=%0d want 1 %b %0d %0d",
          it, Halted, Fault, RetiredCount, ProgramCounter,
          expFault, expCount, expFinalPc);
      end
    end
  endtask

  initial begin
    Reset = 1'b1;
    Run = 1'b0;
    BranchTaken = 1'b0;
    BranchTarget = 32'd0;
    InputConfirm = 1'b0;
    clear_prog();
    test_reset();
    test_straight();
    test_branch();
    test_in();
    test_fault();
    test_restart();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
